operand_capture: RTL

Sequential front end for the calculator datapath. It synchronises and debounces two raw pushbuttons, then latches the 4-bit switch nibble into operand registers A and B in sequence. It sits directly upstream of the math block and seven-segment decoder, which take the registered A/B instead of live switches. It also exports its state for the board LEDs.

---
 rtl/calc_pkg.sv | 13 +
 rtl/button_debouncer.sv | 48 ++++
 rtl/operand_capture.sv | 106 ++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath: operand width and the
// operand-capture FSM state encodings (also driven onto the board LEDs).
package calc_pkg;

    localparam int OPERAND_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'b00,
        ST_HAVE_A = 2'b01,
        ST_READY  = 2'b10
    } state_t;

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser, symmetric counter debouncer and rising-edge strobe
// for one raw pushbutton.
module button_debouncer
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_BITS = 17
) (
    input  logic clock,
    input  logic reset,
    input  logic i_btn,
    output logic o_pulse
);

    logic                     r_s1;
    logic                     r_s2;
    logic                     r_deb;
    logic                     r_deb_d;
    logic [DEBOUNCE_BITS-1:0] r_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_deb   <= 1'b0;
            r_deb_d <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_s1    <= i_btn;
            r_s2    <= r_s1;
            r_deb_d <= r_deb;
            // Any agreement between input and debounced level restarts the count,
            // so only an unbroken run of 2^N differing cycles flips the level.
            if (r_s2 != r_deb) begin
                if (r_cnt == '1) begin
                    r_deb <= r_s2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + DEBOUNCE_BITS'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_pulse = r_deb & ~r_deb_d;

endmodule

// File: rtl/operand_capture.sv
// Calculator front end: debounces load/clear buttons and latches the switch
// nibble into operands A then B, exporting the sequencing state.
module operand_capture
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_BITS = 17,
    parameter int WIDTH         = OPERAND_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_in,
    input  logic             btn_load,
    input  logic             btn_clear,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             operands_valid,
    output logic [1:0]       state,
    output logic             load_pulse
);

    logic [WIDTH-1:0] r_sw_s1;
    logic [WIDTH-1:0] r_sw_s2;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_valid;
    state_t           r_state;
    logic             w_load_pulse;
    logic             w_clear_pulse;

    button_debouncer #(.DEBOUNCE_BITS(DEBOUNCE_BITS)) u_load_deb (
        .clock   (clock),
        .reset   (reset),
        .i_btn   (btn_load),
        .o_pulse (w_load_pulse)
    );

    button_debouncer #(.DEBOUNCE_BITS(DEBOUNCE_BITS)) u_clear_deb (
        .clock   (clock),
        .reset   (reset),
        .i_btn   (btn_clear),
        .o_pulse (w_clear_pulse)
    );

    // Switches are only synchronised; they are sampled at a debounced strobe anyway.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sw_sync
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                r_sw_s1[gi] <= 1'b0;
                r_sw_s2[gi] <= 1'b0;
            end else begin
                r_sw_s1[gi] <= sw_in[gi];
                r_sw_s2[gi] <= r_sw_s1[gi];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_EMPTY;
            r_a     <= '0;
            r_b     <= '0;
            r_valid <= 1'b0;
        end else if (w_clear_pulse) begin
            // Clear dominates a coincident load strobe.
            r_state <= ST_EMPTY;
            r_a     <= '0;
            r_b     <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_load_pulse) begin
                        r_a     <= r_sw_s2;
                        r_state <= ST_HAVE_A;
                    end
                end
                ST_HAVE_A: begin
                    if (w_load_pulse) begin
                        r_b     <= r_sw_s2;
                        r_state <= ST_READY;
                        r_valid <= 1'b1;
                    end
                end
                ST_READY: begin
                    if (w_load_pulse) begin
                        r_a     <= r_sw_s2;
                        r_b     <= '0;
                        r_state <= ST_HAVE_A;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_EMPTY;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign A              = r_a;
    assign B              = r_b;
    assign state          = r_state;
    assign operands_valid = r_valid;
    assign load_pulse     = w_load_pulse;

endmodule
